// File: rtl/snake_pkg.sv
// Shared encodings for the snake game-flow controller.
// Directions, reported modes and the controller state set.
package snake_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_PLAY  = 2'd1;
    localparam logic [1:0] MODE_OVER  = 2'd2;
    localparam logic [1:0] MODE_PAUSE = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WAIT,
        S_APPLE,
        S_PAUSE,
        S_OVER
    } state_e;

    // RUN, WAIT and APPLE all look like active play from outside
    function automatic logic [1:0] mode_of(input state_e s);
        logic [1:0] m;
        m = MODE_IDLE;
        case (s)
            S_IDLE:  m = MODE_IDLE;
            S_RUN:   m = MODE_PLAY;
            S_WAIT:  m = MODE_PLAY;
            S_APPLE: m = MODE_PLAY;
            S_PAUSE: m = MODE_PAUSE;
            S_OVER:  m = MODE_OVER;
            default: m = MODE_IDLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/snake_turn_queue.sv
// One-deep turn buffer: picks a press, rejects same-axis moves,
// and commits the pending turn to dir on each step.
module snake_turn_queue
    import snake_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       commit,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic [1:0] dir
);

    logic [1:0] dir_q, dir_d;
    logic [1:0] pend_q, pend_d;
    logic       pend_vld_q, pend_vld_d;
    logic       press_vld;
    logic [1:0] press_dir;

    always_comb begin
        press_vld = 1'b1;
        press_dir = DIR_UP;
        if (up) begin
            press_dir = DIR_UP;
        end else if (down) begin
            press_dir = DIR_DOWN;
        end else if (left) begin
            press_dir = DIR_LEFT;
        end else if (right) begin
            press_dir = DIR_RIGHT;
        end else begin
            press_vld = 1'b0;
        end
    end

    // bit 1 of the encoding is the axis: 0 vertical, 1 horizontal
    always_comb begin
        dir_d      = dir_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (clr) begin
            dir_d      = DIR_DOWN;
            pend_d     = DIR_UP;
            pend_vld_d = 1'b0;
        end else if (en) begin
            if (commit && pend_vld_q) begin
                dir_d      = pend_q;
                pend_vld_d = 1'b0;
            end
            if (press_vld && (press_dir[1] != dir_d[1])) begin
                pend_d     = press_dir;
                pend_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dir_q      <= DIR_DOWN;
            pend_q     <= DIR_UP;
            pend_vld_q <= 1'b0;
        end else begin
            dir_q      <= dir_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    assign dir = dir_q;

endmodule

// File: rtl/snake_game_sequencer.sv
// Game-flow controller: step schedule, score, apple respawn
// handshake and pause handling for the snake body datapath.
module snake_game_sequencer
    import snake_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 25000000,
    parameter int unsigned SPEED_STEP = 1000000,
    parameter int unsigned MIN_DIV    = 5000000,
    parameter int unsigned MAX_SCORE  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       up,
    input  logic       down,
    input  logic       left,
    input  logic       right,
    output logic       step,
    input  logic       step_done,
    input  logic       collide,
    input  logic       eat,
    output logic       body_clear,
    output logic       apple_req,
    input  logic       apple_ack,
    output logic [1:0] dir,
    output logic [1:0] mode,
    output logic [3:0] score,
    output logic       win
);

    localparam logic [31:0] TICK_W  = 32'(TICK_DIV);
    localparam logic [31:0] SPEED_W = 32'(SPEED_STEP);
    localparam logic [31:0] MIN_W   = 32'(MIN_DIV);
    localparam logic [3:0]  MAX_S   = 4'(MAX_SCORE);

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] div_q, div_d;
    logic [3:0]  score_q, score_d;
    logic        win_q, win_d;
    logic        step_q, step_d;
    logic        body_clear_q, body_clear_d;
    logic        apple_req_q, apple_req_d;
    logic        start_prev_q, start_prev_d;
    logic        pause_prev_q, pause_prev_d;
    logic        pause_pend_q, pause_pend_d;

    logic        start_rise;
    logic        pause_rise;
    logic        go_run;
    logic        clr;
    logic        q_en;
    logic [3:0]  score_inc;
    logic [31:0] div_next;

    assign start_rise = start & ~start_prev_q;
    assign pause_rise = pause & ~pause_prev_q;

    assign score_inc = (score_q == MAX_S) ? score_q : score_q + 4'd1;

    // guarded subtraction so a large SPEED_STEP cannot wrap
    assign div_next = ((div_q > SPEED_W) && ((div_q - SPEED_W) > MIN_W))
                    ? (div_q - SPEED_W) : MIN_W;

    assign q_en = (state_q == S_RUN) || (state_q == S_WAIT)
               || (state_q == S_APPLE) || (state_q == S_PAUSE);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        score_d      = score_q;
        win_d        = win_q;
        step_d       = 1'b0;
        body_clear_d = 1'b0;
        apple_req_d  = apple_req_q;
        pause_pend_d = pause_pend_q;
        start_prev_d = start;
        pause_prev_d = pause;
        go_run       = 1'b0;
        clr          = 1'b0;

        unique case (state_q)
            S_IDLE, S_OVER: begin
                if (start_rise) begin
                    state_d      = S_APPLE;
                    cnt_d        = '0;
                    div_d        = TICK_W;
                    score_d      = '0;
                    win_d        = 1'b0;
                    body_clear_d = 1'b1;
                    apple_req_d  = 1'b1;
                    pause_pend_d = 1'b0;
                    clr          = 1'b1;
                end
            end
            S_RUN: begin
                if (pause_rise) begin
                    state_d = S_PAUSE;
                end else if (cnt_q == div_q - 32'd1) begin
                    cnt_d   = '0;
                    step_d  = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_PAUSE: begin
                if (pause_rise) begin
                    state_d = S_RUN;
                end
            end
            S_WAIT: begin
                pause_pend_d = pause_pend_q | pause_rise;
                if (step_done) begin
                    if (collide) begin
                        state_d      = S_OVER;
                        pause_pend_d = 1'b0;
                    end else if (eat) begin
                        score_d = score_inc;
                        if (score_inc == MAX_S) begin
                            state_d      = S_OVER;
                            win_d        = 1'b1;
                            pause_pend_d = 1'b0;
                        end else begin
                            div_d       = div_next;
                            apple_req_d = 1'b1;
                            state_d     = S_APPLE;
                        end
                    end else begin
                        go_run = 1'b1;
                    end
                end
            end
            S_APPLE: begin
                pause_pend_d = pause_pend_q | pause_rise;
                if (apple_ack) begin
                    apple_req_d = 1'b0;
                    go_run      = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // a pause seen mid-step is honoured as soon as play resumes
        if (go_run) begin
            cnt_d        = '0;
            state_d      = pause_pend_d ? S_PAUSE : S_RUN;
            pause_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            div_q        <= TICK_W;
            score_q      <= '0;
            win_q        <= 1'b0;
            step_q       <= 1'b0;
            body_clear_q <= 1'b0;
            apple_req_q  <= 1'b0;
            start_prev_q <= 1'b0;
            pause_prev_q <= 1'b0;
            pause_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
            score_q      <= score_d;
            win_q        <= win_d;
            step_q       <= step_d;
            body_clear_q <= body_clear_d;
            apple_req_q  <= apple_req_d;
            start_prev_q <= start_prev_d;
            pause_prev_q <= pause_prev_d;
            pause_pend_q <= pause_pend_d;
        end
    end

    snake_turn_queue u_turn_queue (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .en     (q_en),
        .commit (step_d),
        .up     (up),
        .down   (down),
        .left   (left),
        .right  (right),
        .dir    (dir)
    );

    assign step       = step_q;
    assign body_clear = body_clear_q;
    assign apple_req  = apple_req_q;
    assign mode       = mode_of(state_q);
    assign score      = score_q;
    assign win        = win_q;

endmodule
